// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states
// and small opcode-decoding helpers.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MSUB  = 3'b110,
        OP_MSUBU = 3'b111
    } opT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } stateT;

    function automatic int iterCntWidth(input int width);
        return $clog2(width + 1);
    endfunction

    // Even encodings are the signed flavours of each operation.
    function automatic logic isSignedOp(input opT op);
        return ~op[0];
    endfunction

    function automatic logic isDivOp(input opT op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX-stage control and the HI/LO unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             WriteHi;
    logic             WriteLo;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, WriteHi, WriteLo, WriteData,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, WriteHi, WriteLo, WriteData,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 shift-add multiplier and restoring divider on unsigned magnitudes,
// one bit per Step, both sharing a single WIDTH+1 adder.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    input  logic             Step,
    input  logic             DivMode,
    input  logic [WIDTH-1:0] LoadLo,
    input  logic [WIDTH-1:0] LoadM,
    output logic [WIDTH-1:0] ResHi,
    output logic [WIDTH-1:0] ResLo
);

    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] mReg;
    logic [WIDTH:0]   addA;
    logic [WIDTH:0]   addB;
    logic [WIDTH+1:0] addSum;

    // Divide: trial-subtract M from the remainder shifted left by one bit;
    // the carry out is set exactly when the subtraction does not borrow.
    always_comb begin
        addA = DivMode ? {hiReg, loReg[WIDTH-1]} : {1'b0, hiReg};
        addB = {1'b0, mReg};
        if (DivMode) begin
            addB = ~addB;
        end else if (!loReg[0]) begin
            addB = '0;
        end
        addSum = {1'b0, addA} + {1'b0, addB} + {{(WIDTH+1){1'b0}}, DivMode};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hiReg <= '0;
            loReg <= '0;
            mReg  <= '0;
        end else if (Load) begin
            hiReg <= '0;
            loReg <= LoadLo;
            mReg  <= LoadM;
        end else if (Step) begin
            if (DivMode) begin
                hiReg <= addSum[WIDTH+1] ? addSum[WIDTH-1:0] : addA[WIDTH-1:0];
                loReg <= {loReg[WIDTH-2:0], addSum[WIDTH+1]};
            end else begin
                hiReg <= addSum[WIDTH:1];
                loReg <= {addSum[0], loReg[WIDTH-1:1]};
            end
        end
    end

    assign ResHi = hiReg;
    assign ResLo = loReg;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative MULT/DIV/MADD/MSUB engine; owns the
// FSM, sign correction, accumulation and the MTHI/MTLO write path.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit MADD_EN = 1'b1
) (
    input logic               Clk,
    input logic               Rst_n,
    hilo_muldiv_unit_if.slave bus
);

    localparam int             CNT_W     = iterCntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   iterCnt;
    opT                 opReg;
    opT                 opIn;
    logic [WIDTH-1:0]   aReg;
    logic               negRes;
    logic               negRem;
    logic               bZero;
    logic [WIDTH-1:0]   hiR;
    logic [WIDTH-1:0]   loR;
    logic               doneQ;
    logic               divZeroQ;
    logic               signedIn;
    logic               legalOp;
    logic               directWrite;
    logic               accept;
    logic               step;
    logic               commit;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   coreHi;
    logic [WIDTH-1:0]   coreLo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;

    assign opIn        = opT'(bus.Op);
    assign signedIn    = isSignedOp(opIn);
    assign legalOp     = MADD_EN || !bus.Op[2];
    assign directWrite = bus.WriteHi | bus.WriteLo;
    assign magA        = absVal(bus.OperandA, signedIn);
    assign magB        = absVal(bus.OperandB, signedIn);

    muldiv_iter_core #(.WIDTH(WIDTH)) core (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Load    (accept),
        .Step    (step),
        .DivMode (state == S_DIV),
        .LoadLo  (isDivOp(opIn) ? magA : magB),
        .LoadM   (isDivOp(opIn) ? magB : magA),
        .ResHi   (coreHi),
        .ResLo   (coreLo)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // The trailing Done cycle still counts as busy.
                if (bus.Start && legalOp && !directWrite && !doneQ) begin
                    accept    = 1'b1;
                    stateNext = isDivOp(opIn) ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (directWrite) begin
                    stateNext = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (iterCnt == LAST_ITER) stateNext = S_FIX;
                end
            end
            S_FIX: begin
                stateNext = S_IDLE;
                commit    = !directWrite;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            iterCnt <= '0;
            opReg   <= OP_MULT;
            aReg    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            bZero   <= 1'b0;
        end else if (accept) begin
            iterCnt <= '0;
            opReg   <= opIn;
            aReg    <= bus.OperandA;
            negRes  <= signedIn & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
            negRem  <= signedIn & bus.OperandA[WIDTH-1];
            bZero   <= (bus.OperandB == '0);
        end else if (step) begin
            iterCnt <= iterCnt + CNT_W'(1);
        end
    end

    // Quotient sign follows the operand signs, remainder follows the dividend;
    // a zero divisor bypasses sign handling and returns A untouched.
    always_comb begin
        product = negRes ? -{coreHi, coreLo} : {coreHi, coreLo};
        result  = product;
        if (isDivOp(opReg)) begin
            if (bZero) result = {aReg, {WIDTH{1'b1}}};
            else       result = {negRem ? -coreHi : coreHi, negRes ? -coreLo : coreLo};
        end else if (opReg == OP_MADD || opReg == OP_MADDU) begin
            result = {hiR, loR} + product;
        end else if (opReg == OP_MSUB || opReg == OP_MSUBU) begin
            result = {hiR, loR} - product;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hiR      <= '0;
            loR      <= '0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
        end else begin
            doneQ <= commit;
            if (bus.WriteHi)  hiR <= bus.WriteData;
            else if (commit)  hiR <= result[2*WIDTH-1:WIDTH];
            if (bus.WriteLo)  loR <= bus.WriteData;
            else if (commit)  loR <= result[WIDTH-1:0];
            if (accept)                                   divZeroQ <= 1'b0;
            else if (commit && isDivOp(opReg) && bZero)   divZeroQ <= 1'b1;
        end
    end

    assign bus.Busy    = (state != S_IDLE) || doneQ;
    assign bus.Done    = doneQ;
    assign bus.DivZero = divZeroQ;
    assign bus.Hi      = hiR;
    assign bus.Lo      = loR;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed ops push expected HI/LO and
// Done timing; a negedge monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
    hilo_muldiv_unit_if #(.WIDTH(W)) bus2 ();

    hilo_muldiv_unit #(.WIDTH(W), .MADD_EN(1'b1)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    hilo_muldiv_unit #(.WIDTH(W), .MADD_EN(1'b0)) dutNoMadd (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           doneEdge;
        string        name;
    } expT;

    expT sb[$];
    int  errors = 0;
    int  checks = 0;
    int  edgeCnt = 0;

    always @(posedge Clk) edgeCnt <= edgeCnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n && bus.Done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(bus.Done), 64'd0);
            end else begin
                expT e;
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(bus.Hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(bus.Lo), 64'(e.lo));
                check({e.name, "_divzero"}, 64'(bus.DivZero), 64'(e.dz));
                check({e.name, "_done_edge"}, 64'(edgeCnt), 64'(e.doneEdge));
            end
        end
    end

    task automatic runOp(input string name, input opT op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input logic expDz, input bit poke);
        int issueEdge;
        int waited;
        @(negedge Clk);
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        issueEdge    = edgeCnt + 1;
        sb.push_back('{expHi, expLo, expDz, issueEdge + W + 1, name});
        @(negedge Clk);
        bus.Start    = 1'b0;
        bus.Op       = OP_MULTU;
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;
        check({name, "_busy"}, 64'(bus.Busy), 64'd1);
        waited = 0;
        while (bus.Busy && waited < 100) begin
            bus.Start = poke && (waited == 5);
            @(negedge Clk);
            waited++;
        end
        bus.Start = 1'b0;
        check({name, "_busy_fall_edge"}, 64'(edgeCnt), 64'(issueEdge + W + 2));
    endtask

    initial begin
        int waited;
        bus.Start = 1'b0;  bus.Op = OP_MULT;  bus.OperandA = '0;  bus.OperandB = '0;
        bus.WriteHi = 1'b0;  bus.WriteLo = 1'b0;  bus.WriteData = '0;
        bus2.Start = 1'b0; bus2.Op = OP_MULT; bus2.OperandA = '0; bus2.OperandB = '0;
        bus2.WriteHi = 1'b0; bus2.WriteLo = 1'b0; bus2.WriteData = '0;

        repeat (3) @(negedge Clk);
        check("rst_hi", 64'(bus.Hi), 64'd0);
        check("rst_lo", 64'(bus.Lo), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_divzero", 64'(bus.DivZero), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // MADD on an instance without MADD support is ignored; MULTU still works.
        bus2.Start = 1'b1; bus2.Op = OP_MADD; bus2.OperandA = 32'd2; bus2.OperandB = 32'd3;
        @(negedge Clk);
        bus2.Start = 1'b0;
        check("illegal_busy", 64'(bus2.Busy), 64'd0);
        repeat (3) @(negedge Clk);
        check("illegal_busy_later", 64'(bus2.Busy), 64'd0);
        bus2.Start = 1'b1; bus2.Op = OP_MULTU;
        @(negedge Clk);
        bus2.Start = 1'b0;
        waited = 0;
        while (bus2.Busy && waited < 100) begin @(negedge Clk); waited++; end
        check("nomadd_multu_busy_timeout", 64'(bus2.Busy), 64'd0);
        check("nomadd_multu_lo", 64'(bus2.Lo), 64'd6);
        check("nomadd_multu_hi", 64'(bus2.Hi), 64'd0);

        runOp("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        runOp("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        runOp("madd",       OP_MADD,  32'd2,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFF5, 1'b0, 1'b0);
        runOp("msub",       OP_MSUB,  32'd3,        32'd4,        32'hFFFFFFFF, 32'hFFFFFFE9, 1'b0, 1'b0);
        runOp("maddu",      OP_MADDU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFE7, 1'b0, 1'b0);
        runOp("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        runOp("divu_zero",  OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("divzero_sticky", 64'(bus.DivZero), 64'd1);
        runOp("div_min_m1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
        runOp("div_pos_neg", OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        runOp("divu_basic", OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 1'b0);
        runOp("div_zero_s", OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1'b0);
        runOp("mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        runOp("msubu",      OP_MSUBU, 32'd1,        32'd1,        32'h3FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);

        // MTHI and MTLO together.
        @(negedge Clk);
        bus.WriteHi = 1'b1; bus.WriteLo = 1'b1; bus.WriteData = 32'hA5A50F0F;
        @(negedge Clk);
        bus.WriteHi = 1'b0; bus.WriteLo = 1'b0;
        check("mthilo_hi", 64'(bus.Hi), 64'h A5A50F0F);
        check("mthilo_lo", 64'(bus.Lo), 64'h A5A50F0F);

        // Write and Start in the same idle cycle: Start is dropped.
        bus.WriteLo = 1'b1; bus.WriteData = 32'h0000BEEF;
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd3; bus.OperandB = 32'd3;
        @(negedge Clk);
        bus.WriteLo = 1'b0; bus.Start = 1'b0;
        check("wr_start_busy", 64'(bus.Busy), 64'd0);
        check("wr_start_lo", 64'(bus.Lo), 64'h0000BEEF);
        check("wr_start_hi", 64'(bus.Hi), 64'hA5A50F0F);
        repeat (40) @(negedge Clk);

        // MTLO mid-MULTU cancels the op; a Start pulse while busy is ignored.
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd5; bus.OperandB = 32'd5;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);
        bus.Start = 1'b1; bus.OperandA = 32'd9; bus.OperandB = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("cancel_busy_before", 64'(bus.Busy), 64'd1);
        bus.WriteLo = 1'b1; bus.WriteData = 32'h00001234;
        @(negedge Clk);
        bus.WriteLo = 1'b0;
        check("cancel_busy", 64'(bus.Busy), 64'd0);
        check("cancel_lo", 64'(bus.Lo), 64'h00001234);
        check("cancel_hi", 64'(bus.Hi), 64'hA5A50F0F);
        repeat (40) @(negedge Clk);
        check("cancel_stays_idle", 64'(bus.Busy), 64'd0);

        // Asynchronous reset in the middle of a DIVU.
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 32'd100; bus.OperandB = 32'd7;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (15) @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check("midrst_hi", 64'(bus.Hi), 64'd0);
        check("midrst_lo", 64'(bus.Lo), 64'd0);
        check("midrst_busy", 64'(bus.Busy), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        check("midrst_stays_idle", 64'(bus.Busy), 64'd0);

        runOp("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 1'b0);

        repeat (2) @(negedge Clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
